// File: rtl/run_event_monitor_pkg.sv
// Shared types, default widths and helpers for the run event monitor.
package run_event_monitor_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned SAT_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Increment that stops at limit instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] limit);
        return (value >= limit) ? limit : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/led_stretcher.sv
// Retriggerable LED hold: LED stays high STRETCH_CYCLES cycles after the last LOAD.
module led_stretcher #(
    parameter int unsigned STRETCH_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic LOAD,
    output logic LED
);

    localparam int unsigned HOLD_W = $clog2(STRETCH_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Down-counter with reload on LOAD; LED mirrors a nonzero count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_cnt <= '0;
            LED      <= 1'b0;
        end else if (CLR) begin
            hold_cnt <= '0;
            LED      <= 1'b0;
        end else if (LOAD) begin
            hold_cnt <= HOLD_W'(STRETCH_CYCLES);
            LED      <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            LED      <= (hold_cnt > HOLD_W'(1));
        end else begin
            LED      <= 1'b0;
        end
    end

endmodule

// File: rtl/run_event_monitor.sv
// Run event monitor: turns the detector level DET into events, counts them,
// and measures current and longest DET-high run lengths.
// Optional LED pulse stretching is compiled in with `define LED_STRETCH_EN.
module run_event_monitor
    import run_event_monitor_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned LEN_W          = LEN_W_DEF,
    parameter int unsigned STRETCH_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DET,
    input  logic             CLR,
    output logic             EVT_PULSE,
    output logic [CNT_W-1:0] EVT_COUNT,
    output logic             OVF,
    output logic [LEN_W-1:0] RUN_LEN,
    output logic [LEN_W-1:0] MAX_LEN,
    output logic             LED
);

    localparam logic [SAT_W-1:0] LEN_MAX = SAT_W'((64'(1) << LEN_W) - 64'(1));

    // Reject a zero-length LED hold at elaboration.
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("run_event_monitor: STRETCH_CYCLES must be >= 1");
    end

    state_t           state;
    logic             event_c;
    logic             len_wr_c;
    logic [LEN_W-1:0] len_next_c;

    // Event and run-length update decode from the current state and DET.
    always_comb begin
        event_c    = 1'b0;
        len_wr_c   = 1'b0;
        len_next_c = RUN_LEN;
        if (DET) begin
            len_wr_c = 1'b1;
            if (state == IDLE) begin
                event_c    = 1'b1;
                len_next_c = LEN_W'(1);
            end else begin
                len_next_c = LEN_W'(sat_inc(SAT_W'(RUN_LEN), LEN_MAX));
            end
        end
    end

    // FSM plus statistics; CLR wipes statistics but the FSM still follows DET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            EVT_PULSE <= 1'b0;
            EVT_COUNT <= '0;
            OVF       <= 1'b0;
            RUN_LEN   <= '0;
            MAX_LEN   <= '0;
        end else begin
            state <= DET ? RUN : IDLE;
            if (CLR) begin
                EVT_PULSE <= 1'b0;
                EVT_COUNT <= '0;
                OVF       <= 1'b0;
                RUN_LEN   <= '0;
                MAX_LEN   <= '0;
            end else begin
                EVT_PULSE <= event_c;
                if (event_c) begin
                    EVT_COUNT <= EVT_COUNT + CNT_W'(1);
                    if (EVT_COUNT == '1) begin
                        OVF <= 1'b1;
                    end
                end
                if (len_wr_c) begin
                    RUN_LEN <= len_next_c;
                    if (len_next_c > MAX_LEN) begin
                        MAX_LEN <= len_next_c;
                    end
                end
            end
        end
    end

`ifdef LED_STRETCH_EN
    // Stretched LED, loaded on the same edge that raises EVT_PULSE.
    led_stretcher #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_led_stretcher (
        .CLK  (CLK),
        .RESET(RESET),
        .CLR  (CLR),
        .LOAD (event_c && !CLR),
        .LED  (LED)
    );
`else
    // Without stretching the LED is the event pulse itself.
    assign LED = EVT_PULSE;
`endif

endmodule

// File: tb/tb_run_event_monitor.sv
// Directed scoreboard bench for run_event_monitor (CNT_W=LEN_W=8, STRETCH_CYCLES=4).
module tb_run_event_monitor;

    typedef struct packed {
        logic       pulse;
        logic [7:0] count;
        logic       ovf;
        logic [7:0] rlen;
        logic [7:0] mlen;
        logic       led;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DET = 1'b1;
    logic       CLR = 1'b0;
    logic       EVT_PULSE;
    logic [7:0] EVT_COUNT;
    logic       OVF;
    logic [7:0] RUN_LEN;
    logic [7:0] MAX_LEN;
    logic       LED;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   hold_m   = 0;
    exp_t exp_q[$];

    run_event_monitor #(
        .CNT_W(8),
        .LEN_W(8),
        .STRETCH_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .DET      (DET),
        .CLR      (CLR),
        .EVT_PULSE(EVT_PULSE),
        .EVT_COUNT(EVT_COUNT),
        .OVF      (OVF),
        .RUN_LEN  (RUN_LEN),
        .MAX_LEN  (MAX_LEN),
        .LED      (LED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " EVT_PULSE"}, 32'(EVT_PULSE), 32'd0);
        chk({tag, " EVT_COUNT"}, 32'(EVT_COUNT), 32'd0);
        chk({tag, " OVF"},       32'(OVF),       32'd0);
        chk({tag, " RUN_LEN"},   32'(RUN_LEN),   32'd0);
        chk({tag, " MAX_LEN"},   32'(MAX_LEN),   32'd0);
        chk({tag, " LED"},       32'(LED),       32'd0);
    endtask

    // Drive one cycle, queue the expected post-edge outputs, then compare.
    task automatic step(input logic det, input logic clr, input logic p,
                        input logic [7:0] c, input logic o,
                        input logic [7:0] r, input logic [7:0] m);
        exp_t e;
        exp_t got;
        DET = det;
        CLR = clr;
        if (clr)            hold_m = 0;
        else if (p)         hold_m = 4;
        else if (hold_m > 0) hold_m--;
        e.pulse = p;
        e.count = c;
        e.ovf   = o;
        e.rlen  = r;
        e.mlen  = m;
`ifdef LED_STRETCH_EN
        e.led   = (hold_m != 0);
`else
        e.led   = p;
`endif
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        got = exp_q.pop_front();
        chk("EVT_PULSE", 32'(EVT_PULSE), 32'(got.pulse));
        chk("EVT_COUNT", 32'(EVT_COUNT), 32'(got.count));
        chk("OVF",       32'(OVF),       32'(got.ovf));
        chk("RUN_LEN",   32'(RUN_LEN),   32'(got.rlen));
        chk("MAX_LEN",   32'(MAX_LEN),   32'(got.mlen));
        chk("LED",       32'(LED),       32'(got.led));
    endtask

    initial begin
        int lens[3];
        int mx;
        int v;

        // Reset held with DET high: everything stays zero.
        #22;
        chk_zero("reset");

        // Release with DET high: event on the first edge.
        @(negedge CLK);
        RESET = 1'b0;
        step(1, 0, 1, 8'd1, 0, 8'd1, 8'd1);
        step(0, 0, 0, 8'd1, 0, 8'd1, 8'd1);

        // Five-cycle run, then RUN_LEN holds while DET is low.
        step(1, 0, 1, 8'd2, 0, 8'd1, 8'd1);
        for (int k = 2; k <= 5; k++) step(1, 0, 0, 8'd2, 0, 8'(k), 8'(k));
        step(0, 0, 0, 8'd2, 0, 8'd5, 8'd5);
        step(0, 0, 0, 8'd2, 0, 8'd5, 8'd5);

        // Runs of 3, 7, 2 separated by single low cycles.
        step(0, 1, 0, 8'd0, 0, 8'd0, 8'd0);
        lens[0] = 3; lens[1] = 7; lens[2] = 2;
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 1; k <= lens[i]; k++) begin
                if (k > mx) mx = k;
                step(1, 0, (k == 1), 8'(i + 1), 0, 8'(k), 8'(mx));
            end
            step(0, 0, 0, 8'(i + 1), 0, 8'(lens[i]), 8'(mx));
        end

        // 256 single-cycle events wrap the counter and set sticky OVF.
        step(0, 1, 0, 8'd0, 0, 8'd0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 1, 8'(i + 1), (i == 255), 8'd1, 8'd1);
            step(0, 0, 0, 8'(i + 1), (i == 255), 8'd1, 8'd1);
        end
        step(1, 0, 1, 8'd1, 1, 8'd1, 8'd1);
        step(0, 0, 0, 8'd1, 1, 8'd1, 8'd1);
        step(0, 1, 0, 8'd0, 0, 8'd0, 8'd0);

        // CLR on a DET rise suppresses the event for the whole run.
        step(1, 1, 0, 8'd0, 0, 8'd0, 8'd0);
        step(1, 0, 0, 8'd0, 0, 8'd1, 8'd1);
        step(1, 0, 0, 8'd0, 0, 8'd2, 8'd2);
        step(1, 0, 0, 8'd0, 0, 8'd3, 8'd3);
        step(0, 0, 0, 8'd0, 0, 8'd3, 8'd3);
        step(1, 0, 1, 8'd1, 0, 8'd1, 8'd3);
        step(0, 0, 0, 8'd1, 0, 8'd1, 8'd3);

        // Long run saturates RUN_LEN and MAX_LEN at 255.
        step(0, 1, 0, 8'd0, 0, 8'd0, 8'd0);
        for (int k = 1; k <= 260; k++) begin
            v = (k > 255) ? 255 : k;
            step(1, 0, (k == 1), 8'd1, 0, 8'(v), 8'(v));
        end
        step(0, 0, 0, 8'd1, 0, 8'd255, 8'd255);

        // Single event, then an event two cycles after another (LED retrigger).
        step(0, 1, 0, 8'd0, 0, 8'd0, 8'd0);
        step(1, 0, 1, 8'd1, 0, 8'd1, 8'd1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 8'd1, 0, 8'd1, 8'd1);
        step(1, 0, 1, 8'd2, 0, 8'd1, 8'd1);
        step(0, 0, 0, 8'd2, 0, 8'd1, 8'd1);
        step(1, 0, 1, 8'd3, 0, 8'd1, 8'd1);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 8'd3, 0, 8'd1, 8'd1);

        // Asynchronous reset in the middle of a run.
        step(1, 0, 1, 8'd4, 0, 8'd1, 8'd1);
        step(1, 0, 0, 8'd4, 0, 8'd2, 8'd2);
        #2;
        RESET = 1'b1;
        #1;
        chk_zero("midrun_reset");
        hold_m = 0;
        @(negedge CLK);
        RESET = 1'b0;
        DET   = 1'b0;
        step(0, 0, 0, 8'd0, 0, 8'd0, 8'd0);
        step(1, 0, 1, 8'd1, 0, 8'd1, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
